// File: rtl/mealy_code_pkg.sv
// Shared constants, types and code-table decode for the Mealy control-code link.
// Used by the receive-side decoder and reusable by sender-side checkers.
package mealy_code_pkg;

  localparam logic [2:0] ST0 = 3'd0;
  localparam logic [2:0] ST1 = 3'd1;
  localparam logic [2:0] ST2 = 3'd2;
  localparam logic [2:0] ST3 = 3'd3;
  localparam logic [2:0] ST4 = 3'd4;

  localparam logic [4:0] C0_D1 = 5'h10;
  localparam logic [4:0] C0_D0 = 5'h0A;
  localparam logic [4:0] C1_D0 = 5'h17;
  localparam logic [4:0] C1_D1 = 5'h14;
  localparam logic [4:0] C2_D1 = 5'h15;
  localparam logic [4:0] C2_D0 = 5'h13;
  localparam logic [4:0] C3_D0 = 5'h1B;
  localparam logic [4:0] C3_D1 = 5'h09;
  localparam logic [4:0] C4_D1 = 5'h1D;
  localparam logic [4:0] C4_D0 = 5'h0D;

  typedef struct packed {
    logic       legal;
    logic [2:0] st;
    logic       din2;
  } code_info_t;

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } trk_t;

  function automatic code_info_t code_decode(
    input logic [4:0] code
  );
    code_info_t r;
    r = '0;
    case (code)
      C0_D1:   r = '{1'b1, ST0, 1'b1};
      C0_D0:   r = '{1'b1, ST0, 1'b0};
      C1_D0:   r = '{1'b1, ST1, 1'b0};
      C1_D1:   r = '{1'b1, ST1, 1'b1};
      C2_D1:   r = '{1'b1, ST2, 1'b1};
      C2_D0:   r = '{1'b1, ST2, 1'b0};
      C3_D0:   r = '{1'b1, ST3, 1'b0};
      C3_D1:   r = '{1'b1, ST3, 1'b1};
      C4_D1:   r = '{1'b1, ST4, 1'b1};
      C4_D0:   r = '{1'b1, ST4, 1'b0};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mealy_code_lut.sv
// Combinational code-to-{legal, state, din2} lookup.
// No state; safe to share with the sender-side checker.
module mealy_code_lut
  import mealy_code_pkg::*;
(
  input  logic [4:0] code,
  output logic       legal,
  output logic [2:0] st,
  output logic       din2
);

  code_info_t info;

  assign info  = code_decode(code);
  assign legal = info.legal;
  assign st    = info.st;
  assign din2  = info.din2;

endmodule

// File: rtl/mealy_code_decoder.sv
// Receive-side Mealy code decoder: state/DIN2 recovery, DIN1 inference, lock FSM.
// Define MEALY_DEC_ERR_CNT_EN to add the saturating ERR_CNT output.
module mealy_code_decoder
  import mealy_code_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       CODE_IN,
  input  logic             CODE_VLD,
  output logic             DEC_VLD,
  output logic [2:0]       ST_OUT,
  output logic             CTRL_OUT,
  output logic             DIN1_OUT,
  output logic             DIN1_VLD,
  output logic             LOCKED,
  output logic             ILLEGAL_CODE,
  output logic             SEQ_ERR,
`ifdef MEALY_DEC_ERR_CNT_EN
  output logic [7:0]       ERR_CNT,
`endif
  output logic [CNT_W-1:0] WRAP_CNT
);

  logic       legal;
  logic [2:0] s;
  logic       d2;

  mealy_code_lut u_lut (
    .code  (CODE_IN),
    .legal (legal),
    .st    (s),
    .din2  (d2)
  );

  trk_t             fsm_q, fsm_n;
  logic [2:0]       prev_q, prev_n;
  logic [2:0]       st_q, st_n;
  logic             ctrl_q, ctrl_n;
  logic             din1_q, din1_n;
  logic             dvld_n, dec_n, ill_n, seq_n;
  logic             dvld_q, dec_q, ill_q, seq_q;
  logic [CNT_W-1:0] wrap_q, wrap_n;
  logic             p4, same, step, wrap_hit;

  assign p4       = prev_q == ST4;
  assign same     = !p4 && s == prev_q;
  assign step     = !p4 && s == prev_q + 3'd1;
  assign wrap_hit = p4 && s == ST0;

  always_comb begin
    fsm_n  = fsm_q;
    prev_n = prev_q;
    st_n   = st_q;
    ctrl_n = ctrl_q;
    din1_n = din1_q;
    wrap_n = wrap_q;
    dvld_n = 1'b0;
    dec_n  = 1'b0;
    ill_n  = 1'b0;
    seq_n  = 1'b0;
    if (CODE_VLD) begin
      if (!legal) begin
        ill_n = 1'b1;
        fsm_n = HUNT;
      end else begin
        dec_n  = 1'b1;
        st_n   = s;
        ctrl_n = d2;
        prev_n = s;
        if (fsm_q == HUNT) begin
          if (s == ST0) fsm_n = TRACK;
        end else begin
          dvld_n = 1'b1;
          unique case (1'b1)
            same: din1_n = 1'b0;
            step: din1_n = 1'b1;
            p4 && s == ST4: din1_n = 1'b1;
            wrap_hit: begin
              din1_n = 1'b0;
              wrap_n = wrap_q + CNT_W'(1);
            end
            default: begin
              dvld_n = 1'b0;
              seq_n  = 1'b1;
              fsm_n  = HUNT;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      fsm_q  <= HUNT;
      prev_q <= ST0;
      st_q   <= ST0;
      ctrl_q <= 1'b0;
      din1_q <= 1'b0;
      wrap_q <= '0;
      dvld_q <= 1'b0;
      dec_q  <= 1'b0;
      ill_q  <= 1'b0;
      seq_q  <= 1'b0;
    end else begin
      fsm_q  <= fsm_n;
      prev_q <= prev_n;
      st_q   <= st_n;
      ctrl_q <= ctrl_n;
      din1_q <= din1_n;
      wrap_q <= wrap_n;
      dvld_q <= dvld_n;
      dec_q  <= dec_n;
      ill_q  <= ill_n;
      seq_q  <= seq_n;
    end
  end

`ifdef MEALY_DEC_ERR_CNT_EN
  logic [7:0] err_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_q <= 8'd0;
    end else if ((ill_n || seq_n) && err_q != 8'hFF) begin
      err_q <= err_q + 8'd1;
    end
  end

  assign ERR_CNT = err_q;
`endif

  assign DEC_VLD      = dec_q;
  assign ST_OUT       = st_q;
  assign CTRL_OUT     = ctrl_q;
  assign DIN1_OUT     = din1_q;
  assign DIN1_VLD     = dvld_q;
  assign LOCKED       = fsm_q == TRACK;
  assign ILLEGAL_CODE = ill_q;
  assign SEQ_ERR      = seq_q;
  assign WRAP_CNT     = wrap_q;

endmodule
